// File: rtl/ddr_cmd_sequencer_if.sv
// Request bus into the DDR4 command sequencer.
// master drives the request and bl8; slave returns req_ready.
interface ddr_cmd_sequencer_if #(
  parameter int ROW_W = 17,
  parameter int COL_W = 10
);
  logic             req_valid;
  logic             req_ready;
  logic             req_rd;
  logic [1:0]       req_bg;
  logic [1:0]       req_ba;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic             bl8;

  modport master (
    output req_valid, req_rd, req_bg,
    output req_ba, req_row, req_col, bl8,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_rd, req_bg,
    input  req_ba, req_row, req_col, bl8,
    output req_ready
  );
endinterface

// File: rtl/ddr_cmd_sequencer.sv
// Open-page DDR4 command sequencer: PRE/ACT/RD/WR/PREA/REF with timing gaps.
// Ports: CK_t, reset_n, req (slave), ref_req/ref_ack, DDR4 pins, cas status.
module ddr_cmd_sequencer #(
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_RFC = 16,
  parameter int ROW_W = 17,
  parameter int COL_W = 10
) (
  input  logic        CK_t,
  input  logic        reset_n,
  ddr_cmd_sequencer_if.slave req,
  input  logic        ref_req,
  output logic        ref_ack,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [9:0]  A9_A0,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic        no_act_rdy,
  output logic        cas_valid,
  output logic        cas_rd
);

  localparam int MA = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int MB = (MA > T_RFC) ? MA : T_RFC;
  localparam int MAXT = (MB > 4) ? MB : 4;
  localparam int CW = $clog2(MAXT + 1);

  typedef enum logic [3:0] {
    IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT,
    CAS, BURST_WAIT, PREA, PREA_WAIT,
    REF, REF_WAIT
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic             rd_q, rd_d;
  logic             bl8_q, bl8_d;
  logic             hit_q, hit_d;
  logic [1:0]       bg_q, bg_d;
  logic [1:0]       ba_q, ba_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  logic [15:0]      open_q;
  logic [ROW_W-1:0] row_tbl [16];

  logic [3:0] idx_in, idx_d;
  logic       accept;
  logic       rdy_q;

  logic [4:0]  c_d;
  logic [13:0] a_d;
  logic [1:0]  bgo_d, bao_d;
  logic [16:0] act_row;

  assign req.req_ready = rdy_q;
  assign idx_in = {req.req_bg, req.req_ba};
  assign idx_d  = {bg_d, ba_d};
  assign accept = (state_q == IDLE) &&
                  req.req_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    bl8_d   = bl8_q;
    hit_d   = hit_q;
    bg_d    = bg_q;
    ba_d    = ba_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          rd_d  = req.req_rd;
          bl8_d = req.bl8;
          bg_d  = req.req_bg;
          ba_d  = req.req_ba;
          row_d = req.req_row;
          col_d = req.req_col;
          hit_d = 1'b0;
          if (open_q[idx_in] &&
              row_tbl[idx_in] == req.req_row) begin
            hit_d   = 1'b1;
            state_d = CAS;
            cnt_d   = req.bl8 ? CW'(4) : CW'(2);
          end else if (open_q[idx_in]) begin
            state_d = PRE;
            cnt_d   = CW'(T_RP);
          end else begin
            state_d = ACT;
            cnt_d   = CW'(T_RCD);
          end
        end else if (ref_req) begin
          if (|open_q) begin
            state_d = PREA;
            cnt_d   = CW'(T_RP);
          end else begin
            state_d = REF;
            cnt_d   = CW'(T_RFC);
          end
        end
      end
      PRE, PRE_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = ACT;
          cnt_d   = CW'(T_RCD);
        end else begin
          state_d = PRE_WAIT;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      ACT, ACT_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = CAS;
          cnt_d   = bl8_q ? CW'(4) : CW'(2);
        end else begin
          state_d = ACT_WAIT;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      CAS: state_d = BURST_WAIT;
      BURST_WAIT: begin
        if (cnt_q <= CW'(1)) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      PREA, PREA_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          state_d = REF;
          cnt_d   = CW'(T_RFC);
        end else begin
          state_d = PREA_WAIT;
          cnt_d   = cnt_q - CW'(1);
        end
      end
      REF: state_d = REF_WAIT;
      REF_WAIT: begin
        if (cnt_q <= CW'(1)) state_d = IDLE;
        else cnt_d = cnt_q - CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Command states last one cycle, so the pins follow the next state.
  always_comb begin
    c_d     = 5'b11111;
    a_d     = '0;
    bgo_d   = '0;
    bao_d   = '0;
    act_row = 17'(row_d);
    unique case (state_d)
      ACT: begin
        c_d   = {2'b00, act_row[16:14]};
        a_d   = act_row[13:0];
        bgo_d = bg_d;
        bao_d = ba_d;
      end
      PRE: begin
        c_d   = 5'b01010;
        bgo_d = bg_d;
        bao_d = ba_d;
      end
      PREA: begin
        c_d     = 5'b01010;
        a_d[10] = 1'b1;
      end
      CAS: begin
        c_d      = rd_d ? 5'b01101 : 5'b01100;
        a_d[12]  = bl8_d;
        a_d[9:0] = 10'(col_d);
        bgo_d    = bg_d;
        bao_d    = ba_d;
      end
      REF: c_d = 5'b01001;
      default: c_d = 5'b11111;
    endcase
  end

  always_ff @(posedge CK_t) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_q       <= 1'b0;
      bl8_q      <= 1'b0;
      hit_q      <= 1'b0;
      bg_q       <= '0;
      ba_q       <= '0;
      row_q      <= '0;
      col_q      <= '0;
      open_q     <= '0;
      rdy_q      <= 1'b0;
      ref_ack    <= 1'b0;
      no_act_rdy <= 1'b0;
      cas_valid  <= 1'b0;
      cas_rd     <= 1'b0;
      {cs_n, act_n, RAS_n_A16,
       CAS_n_A15, WE_n_A14} <= 5'b11111;
      {A13, A12_BC_n, A11,
       A10_AP, A9_A0} <= '0;
      bg_addr    <= '0;
      ba_addr    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_q       <= rd_d;
      bl8_q      <= bl8_d;
      hit_q      <= hit_d;
      bg_q       <= bg_d;
      ba_q       <= ba_d;
      row_q      <= row_d;
      col_q      <= col_d;
      rdy_q      <= (state_d == IDLE) && !ref_req;
      ref_ack    <= (state_d == REF_WAIT) &&
                    (cnt_d == CW'(1));
      no_act_rdy <= (state_d == CAS) && hit_d;
      cas_valid  <= (state_d == CAS);
      cas_rd     <= (state_d == CAS) && rd_d;
      {cs_n, act_n, RAS_n_A16,
       CAS_n_A15, WE_n_A14} <= c_d;
      {A13, A12_BC_n, A11,
       A10_AP, A9_A0} <= a_d;
      bg_addr    <= bgo_d;
      ba_addr    <= bao_d;
      if (state_d == ACT && state_q != ACT)
        open_q[idx_d] <= 1'b1;
      else if (state_d == PRE && state_q != PRE)
        open_q[idx_d] <= 1'b0;
      else if (state_d == PREA || state_d == REF)
        open_q <= '0;
    end
  end

  always_ff @(posedge CK_t) begin
    if (state_d == ACT && state_q != ACT)
      row_tbl[idx_d] <= row_d;
  end

endmodule
